// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM read port, decoder handshake, and branch feedback.
// The master modport is the fetch unit; the slave modport is ROM/decoder/ALU.
interface instr_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 21
);
  logic               i_run;
  logic               o_rom_en;
  logic [ADDR_W-1:0]  o_rom_addr;
  logic [INSTR_W-1:0] i_rom_data;
  logic [INSTR_W-1:0] o_instr;
  logic               o_instr_valid;
  logic               i_stall;
  logic               i_branch_taken;
  logic [ADDR_W-1:0]  i_branch_target;
  logic [ADDR_W-1:0]  o_pc;
  logic               o_halted;

  modport master (
    input  i_run, i_rom_data, i_stall, i_branch_taken, i_branch_target,
    output o_rom_en, o_rom_addr, o_instr, o_instr_valid, o_pc, o_halted
  );

  modport slave (
    output i_run, i_rom_data, i_stall, i_branch_taken, i_branch_target,
    input  o_rom_en, o_rom_addr, o_instr, o_instr_valid, o_pc, o_halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter and sequencer that reads a 1-cycle-latency instruction ROM
// and hands instructions to the decoder with a valid/stall handshake.
//
// state   | meaning
// IDLE    | waiting for i_run, no ROM activity
// FETCH   | o_rom_en high for this single cycle, address = pc
// WAIT    | ROM data arrives, captured into o_instr
// ISSUE   | o_instr valid, held while i_stall; consumed when i_stall low
// HALT    | halt opcode consumed, waits for i_run low
module instr_fetch_unit #(
  parameter int                  ADDR_W    = 8,
  parameter int                  INSTR_W   = 21,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [4:0]          HALT_OP   = 5'b11111,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 21'h010000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               rom_en_q, rom_en_d;
  logic               halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    rom_en_d = 1'b0;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_run) begin
          state_d  = S_FETCH;
          pc_d     = RESET_PC;
          rom_en_d = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = bus.i_rom_data;
        valid_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.i_stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          // Halt wins over any branch resolved in the same cycle.
          if (instr_q[INSTR_W-1 -: 5] == HALT_OP) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d  = S_FETCH;
            rom_en_d = 1'b1;
            pc_d     = bus.i_branch_taken ? bus.i_branch_target
                                          : pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        if (!bus.i_run) begin
          halted_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      rom_en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      rom_en_q <= rom_en_d;
      halted_q <= halted_d;
    end
  end

  assign bus.o_rom_en      = rom_en_q;
  assign bus.o_rom_addr    = pc_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_valid = valid_q;
  assign bus.o_halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, fetch/issue scoreboard and
// per-scenario tasks with inline checks.
module tb_instr_fetch_unit;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 21;
  localparam logic [INSTR_W-1:0] NOP    = 21'h010000;
  localparam logic [INSTR_W-1:0] HALT_I = 21'h1F0000;
  localparam logic [INSTR_W-1:0] ADDI   = 21'h051203;
  localparam logic [INSTR_W-1:0] BEQ    = 21'h0C1240;
  localparam logic [INSTR_W-1:0] ADD4   = 21'h023104;
  localparam logic [INSTR_W-1:0] ADDFF  = 21'h0221FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch_unit dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [INSTR_W-1:0] rom [0:255];
  always @(posedge clk) if (bus.o_rom_en) bus.i_rom_data <= rom[bus.o_rom_addr];

  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W-1:0]         exp_fetch [$];
  logic [ADDR_W+INSTR_W-1:0] exp_issue [$];
  logic [ADDR_W-1:0]         sb_addr;
  logic [ADDR_W+INSTR_W-1:0] sb_issue;
  logic                      prev_valid = 1'b0;

  // Scoreboard: every ROM read and every newly valid instruction is popped.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_rom_en) begin
        vectors++;
        if (exp_fetch.size() == 0) begin
          miscompares++;
          $display("FAIL fetch_sb: unexpected fetch addr %h, none expected", bus.o_rom_addr);
        end else begin
          sb_addr = exp_fetch.pop_front();
          if (bus.o_rom_addr !== sb_addr) begin
            miscompares++;
            $display("FAIL fetch_sb: addr %h, expected %h", bus.o_rom_addr, sb_addr);
          end
        end
      end
      if (bus.o_instr_valid && !prev_valid) begin
        vectors++;
        if (exp_issue.size() == 0) begin
          miscompares++;
          $display("FAIL issue_sb: unexpected instr %h at pc %h", bus.o_instr, bus.o_pc);
        end else begin
          sb_issue = exp_issue.pop_front();
          if ({bus.o_pc, bus.o_instr} !== sb_issue) begin
            miscompares++;
            $display("FAIL issue_sb: pc/instr %h/%h, expected %h/%h", bus.o_pc, bus.o_instr,
                     sb_issue[ADDR_W+INSTR_W-1:INSTR_W], sb_issue[INSTR_W-1:0]);
          end
        end
      end
      prev_valid = bus.o_instr_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.o_instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.o_instr_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: o_instr_valid still %b after 20 cycles, expected 1", tag, bus.o_instr_valid);
    end
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!bus.o_halted && n < 20) begin
      step();
      n++;
    end
    if (!bus.o_halted) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: o_halted still %b after 20 cycles, expected 1", tag, bus.o_halted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors += 6;
    if (bus.o_rom_en !== 1'b0) begin miscompares++; $display("FAIL rst_rom_en: %b expected 0", bus.o_rom_en); end
    if (bus.o_rom_addr !== 8'h00) begin miscompares++; $display("FAIL rst_rom_addr: %h expected 00", bus.o_rom_addr); end
    if (bus.o_instr !== NOP) begin miscompares++; $display("FAIL rst_instr: %h expected %h", bus.o_instr, NOP); end
    if (bus.o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: %b expected 0", bus.o_instr_valid); end
    if (bus.o_halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: %b expected 0", bus.o_halted); end
    if (bus.o_pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc: %h expected 00", bus.o_pc); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_run();
    int en_cnt;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    exp_issue.push_back({8'h00, ADDI});
    exp_issue.push_back({8'h01, HALT_I});
    bus.i_run = 1'b1;
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b1 || bus.o_rom_addr !== 8'h00) begin
      miscompares++; $display("FAIL basic_fetch0: en/addr %b/%h expected 1/00", bus.o_rom_en, bus.o_rom_addr);
    end
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_wait: en/valid %b/%b expected 0/0", bus.o_rom_en, bus.o_instr_valid);
    end
    step();
    vectors++;
    if (bus.o_instr_valid !== 1'b1 || bus.o_instr !== ADDI) begin
      miscompares++; $display("FAIL basic_latency: valid/instr %b/%h expected 1/%h", bus.o_instr_valid, bus.o_instr, ADDI);
    end
    step();
    vectors++;
    if (bus.o_instr_valid !== 1'b0 || bus.o_instr !== NOP) begin
      miscompares++; $display("FAIL basic_consume: valid/instr %b/%h expected 0/%h", bus.o_instr_valid, bus.o_instr, NOP);
    end
    wait_halt("basic");
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_rom_en) en_cnt++;
      step();
    end
    vectors++;
    if (en_cnt != 0 || bus.o_halted !== 1'b1 || bus.o_pc !== 8'h01) begin
      miscompares++; $display("FAIL basic_halt_quiet: rom_en cycles/halted/pc %0d/%b/%h expected 0/1/01", en_cnt, bus.o_halted, bus.o_pc);
    end
    bus.i_run = 1'b0;
    step();
    vectors++;
    if (bus.o_halted !== 1'b0) begin miscompares++; $display("FAIL basic_unhalt: halted %b expected 0", bus.o_halted); end
  endtask

  task automatic test_stall();
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    bus.i_run = 1'b1;
    step();
    wait_valid("stall_pc0");
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 8'h04;
    exp_fetch.push_back(8'h04);
    exp_issue.push_back({8'h04, ADD4});
    step();
    bus.i_branch_taken = 1'b0;
    wait_valid("stall_pc4");
    bus.i_stall = 1'b1;
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.o_instr !== ADD4 || bus.o_pc !== 8'h04 || bus.o_instr_valid !== 1'b1 || bus.o_rom_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d instr/pc/valid/en %h/%h/%b/%b expected %h/04/1/0",
                 i, bus.o_instr, bus.o_pc, bus.o_instr_valid, bus.o_rom_en, ADD4);
      end
    end
    bus.i_stall = 1'b0;
    bus.i_branch_taken = 1'b0;
    exp_fetch.push_back(8'h05);
    exp_issue.push_back({8'h05, HALT_I});
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b1 || bus.o_rom_addr !== 8'h05) begin
      miscompares++; $display("FAIL stall_release: en/addr %b/%h expected 1/05", bus.o_rom_en, bus.o_rom_addr);
    end
    wait_halt("stall");
    bus.i_run = 1'b0;
    step();
  endtask

  task automatic test_branch(input logic taken, input logic [ADDR_W-1:0] next_addr);
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    bus.i_run = 1'b1;
    step();
    wait_valid("branch_pc0");
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 8'h02;
    exp_fetch.push_back(8'h02);
    exp_issue.push_back({8'h02, BEQ});
    step();
    bus.i_branch_taken = 1'b0;
    wait_valid("branch_beq");
    bus.i_branch_taken = taken;
    bus.i_branch_target = 8'h40;
    exp_fetch.push_back(next_addr);
    exp_issue.push_back({next_addr, HALT_I});
    step();
    bus.i_branch_taken = 1'b0;
    vectors++;
    if (bus.o_rom_en !== 1'b1 || bus.o_rom_addr !== next_addr || bus.o_pc !== next_addr) begin
      miscompares++; $display("FAIL branch_target: en/addr/pc %b/%h/%h expected 1/%h/%h",
                              bus.o_rom_en, bus.o_rom_addr, bus.o_pc, next_addr, next_addr);
    end
    wait_halt("branch");
    bus.i_run = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    bus.i_run = 1'b1;
    step();
    bus.i_run = 1'b0;
    wait_valid("wrap_pc0");
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 8'hFF;
    exp_fetch.push_back(8'hFF);
    exp_issue.push_back({8'hFF, ADDFF});
    step();
    bus.i_branch_taken = 1'b0;
    wait_valid("wrap_ff");
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b1 || bus.o_rom_addr !== 8'h00 || bus.o_pc !== 8'h00) begin
      miscompares++; $display("FAIL wrap_addr: en/addr/pc %b/%h/%h expected 1/00/00", bus.o_rom_en, bus.o_rom_addr, bus.o_pc);
    end
    wait_valid("wrap_pc0b");
    exp_fetch.push_back(8'h01);
    exp_issue.push_back({8'h01, HALT_I});
    step();
    wait_halt("wrap");
    step();
    vectors++;
    if (bus.o_halted !== 1'b0) begin miscompares++; $display("FAIL wrap_idle: halted %b expected 0", bus.o_halted); end
  endtask

  task automatic test_halt_branch();
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    bus.i_run = 1'b1;
    step();
    wait_valid("hb_pc0");
    exp_fetch.push_back(8'h01);
    exp_issue.push_back({8'h01, HALT_I});
    step();
    wait_valid("hb_halt");
    bus.i_branch_taken = 1'b1;
    bus.i_branch_target = 8'h40;
    step();
    bus.i_branch_taken = 1'b0;
    vectors++;
    if (bus.o_halted !== 1'b1 || bus.o_rom_en !== 1'b0 || bus.o_pc !== 8'h01) begin
      miscompares++; $display("FAIL hb_ignore_branch: halted/en/pc %b/%b/%h expected 1/0/01", bus.o_halted, bus.o_rom_en, bus.o_pc);
    end
    step();
    step();
    vectors++;
    if (bus.o_halted !== 1'b1) begin miscompares++; $display("FAIL hb_hold: halted %b expected 1", bus.o_halted); end
    bus.i_run = 1'b0;
    step();
    vectors++;
    if (bus.o_halted !== 1'b0) begin miscompares++; $display("FAIL hb_idle: halted %b expected 0", bus.o_halted); end
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL hb_idle_quiet: en/valid %b/%b expected 0/0", bus.o_rom_en, bus.o_instr_valid);
    end
    bus.i_run = 1'b1;
    exp_fetch.push_back(8'h00);
    exp_issue.push_back({8'h00, ADDI});
    step();
    vectors++;
    if (bus.o_rom_en !== 1'b1 || bus.o_rom_addr !== 8'h00) begin
      miscompares++; $display("FAIL hb_restart: en/addr %b/%h expected 1/00", bus.o_rom_en, bus.o_rom_addr);
    end
    wait_valid("hb_restart");
    exp_fetch.push_back(8'h01);
    exp_issue.push_back({8'h01, HALT_I});
    step();
    wait_halt("hb_restart");
    bus.i_run = 1'b0;
    step();
  endtask

  task automatic test_reset_wait();
    exp_fetch.push_back(8'h00);
    bus.i_run = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_instr_valid !== 1'b0 || bus.o_instr !== NOP || bus.o_rom_en !== 1'b0 ||
        bus.o_rom_addr !== 8'h00 || bus.o_halted !== 1'b0 || bus.o_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL rstw_async: valid/instr/en/addr/halted/pc %b/%h/%b/%h/%b/%h expected 0/%h/0/00/0/00",
               bus.o_instr_valid, bus.o_instr, bus.o_rom_en, bus.o_rom_addr, bus.o_halted, bus.o_pc, NOP);
    end
    bus.i_run = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (bus.o_instr_valid !== 1'b0 || bus.o_instr !== NOP) begin
        miscompares++; $display("FAIL rstw_discard: cycle %0d valid/instr %b/%h expected 0/%h", i, bus.o_instr_valid, bus.o_instr, NOP);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    rom[8'h00] = ADDI;
    rom[8'h01] = HALT_I;
    rom[8'h02] = BEQ;
    rom[8'h03] = HALT_I;
    rom[8'h04] = ADD4;
    rom[8'h05] = HALT_I;
    rom[8'h40] = HALT_I;
    rom[8'hFF] = ADDFF;
    bus.i_run = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_branch_target = 8'h00;
    bus.i_rom_data = NOP;
    rst = 1'b1;

    test_reset();
    test_basic_run();
    test_stall();
    test_branch(1'b1, 8'h40);
    test_branch(1'b0, 8'h03);
    test_wrap();
    test_halt_branch();
    test_reset_wait();

    vectors++;
    if (exp_fetch.size() != 0 || exp_issue.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d fetches and %0d issues never seen, expected 0/0", exp_fetch.size(), exp_issue.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction sequencer that produces the 21-bit instruction words consumed by the instruction decoder.
- Holds the program counter and reads a synchronous instruction ROM with 1-cycle read latency.
- Presents each instruction with a valid/stall handshake.
- Applies next-PC selection: sequential, branch redirect from the ALU's BEQ/BEQF result, or halt.

Parameters:
- ADDR_W, 8, program counter / ROM address width; matches the 8-bit address field.
- INSTR_W, 21, instruction width: [20:16] opcode, [15:12] dest, [11:8] src, [7:0] imm/addr.
- RESET_PC, 0, PC loaded when a run starts.
- HALT_OP, 5'b11111, opcode that stops fetching.
- NOP_INSTR, 21'h010000, value of o_instr when no instruction is held (opcode 00001, decodes to ALU NOP).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_run  in  1  level; start fetching from RESET_PC when idle.
- o_rom_en  out  1  ROM read enable.
- o_rom_addr  out  ADDR_W  ROM read address.
- i_rom_data  in  INSTR_W  ROM read data, valid the cycle after o_rom_en.
- o_instr  out  INSTR_W  instruction to decoder (registered).
- o_instr_valid  out  1  o_instr holds an unconsumed instruction.
- i_stall  in  1  downstream busy (ALU/I2C controller); holds the current instruction.
- i_branch_taken  in  1  branch resolved for the issued instruction; sampled only at consume.
- i_branch_target  in  ADDR_W  branch destination; sampled with i_branch_taken.
- o_pc  out  ADDR_W  address of the instruction in o_instr / being fetched.
- o_halted  out  1  HALT_OP consumed; fetch stopped.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch or mid-stall):
  - state IDLE, pc=RESET_PC, o_instr=NOP_INSTR.
  - o_instr_valid=0, o_rom_en=0, o_rom_addr=0, o_halted=0.
  - Any in-flight ROM data is discarded.
- All outputs are registered. o_rom_addr always equals pc.
- FSM states:
  - IDLE: o_rom_en=0. If i_run=1, go to FETCH with pc=RESET_PC.
  - FETCH: assert o_rom_en=1 for exactly this cycle, then go to WAIT.
  - WAIT: o_rom_en=0. Capture i_rom_data into o_instr, set o_instr_valid=1, go to ISSUE.
  - ISSUE: hold o_instr and o_instr_valid while i_stall=1; nothing else changes. On a cycle with i_stall=0 the instruction is consumed:
    - clear o_instr_valid and set o_instr=NOP_INSTR on the next edge.
    - If o_instr[20:16]==HALT_OP: go to HALT, o_halted=1. Branch inputs are ignored.
    - Else if i_branch_taken=1: pc<=i_branch_target, go to FETCH.
    - Else: pc<=pc+1 modulo 2^ADDR_W (255 wraps to 0, no flag), go to FETCH.
  - HALT: o_halted=1, o_rom_en=0, pc frozen. When i_run=0, clear o_halted and go to IDLE. A new run requires i_run to go 0 and then 1.
- Timing:
  - Unstalled throughput is 1 instruction per 3 cycles (FETCH, WAIT, ISSUE).
  - Latency from i_run=1 in IDLE to first o_instr_valid=1 is 3 edges.
- Boundary cases:
  - i_branch_taken and i_branch_target are don't-care outside ISSUE and while i_stall=1.
  - A branch to the current pc is legal (tight loop).
  - i_run deasserted mid-program has no effect; the unit only stops on HALT_OP or reset.
  - i_stall asserted during FETCH/WAIT is ignored; it only holds the ISSUE state.
  - i_stall held indefinitely keeps o_instr stable with no ROM activity.

Test Plan:
- Reset, i_run=1, ROM[0]=21'h05_1203 (ADDI), ROM[1]=HALT. Required response:
  - o_rom_en high 1 cycle with addr 0.
  - o_instr=21'h051203 with valid 3 cycles after i_run.
  - Then addr 1 is fetched, then o_halted=1 with o_rom_en quiet.
- Stall: i_stall=1 for 5 cycles while the instruction at pc=4 is valid. Required: o_instr and o_pc=4 stable for 5 cycles, no o_rom_en. On release, the next fetch is at addr 5.
- Branch: ROM[2]=BEQ. At consume, i_branch_taken=1 with i_branch_target=8'h40. Required: next o_rom_addr=8'h40 and o_pc=8'h40. With i_branch_taken=0, the next address is 3.
- Wrap: branch to 8'hFF, ROM[FF]=ADD not taken. Required: next fetch address 8'h00.
- HALT with i_branch_taken=1 asserted in the same cycle: branch ignored, o_halted=1. Then i_run=0 gives IDLE and o_halted=0. Then i_run=1 restarts at addr 0.
- Assert i_rst during WAIT. Required: outputs return immediately to reset values, o_instr=NOP_INSTR, and the late ROM data is never presented.
